// File: rtl/sram_periph_responder.sv
// Peripheral responder on the CPU's SRAM-style data port: LED/switch, timer with
// compare interrupt, scratch register and a byte TX FIFO. Read data is registered.
module sram_periph_responder #(
   parameter logic [31:0] BASE       = 32'h1FAF_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out,
   output logic        timer_irq,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   localparam logic [15:0] OFF_LED     = 16'h0000;
   localparam logic [15:0] OFF_SWITCH  = 16'h0004;
   localparam logic [15:0] OFF_TIMER   = 16'h0008;
   localparam logic [15:0] OFF_COMPARE = 16'h000C;
   localparam logic [15:0] OFF_STATUS  = 16'h0010;
   localparam logic [15:0] OFF_TXDATA  = 16'h0014;
   localparam logic [15:0] OFF_SCRATCH = 16'h0018;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   logic [31:0]      rdata_q, rdata_d;
   logic [15:0]      led_q, led_d;
   logic [31:0]      timer_q, timer_d;
   logic [31:0]      compare_q, compare_d;
   logic [31:0]      scratch_q, scratch_d;
   logic             irq_q, irq_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       fifo_q [FIFO_DEPTH];
   logic [7:0]       fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic        hit, rd_hit, wr_hit, rd_miss;
   logic [15:0] offset;
   logic        wr_led, wr_timer, wr_compare, wr_status, wr_txdata, wr_scratch;
   logic        fifo_empty, fifo_full, push_req, push, pop;
   logic        irq_clr, ovf_clr;
   logic [31:0] status_word, rd_mux;
   logic        unused_addr;

   assign unused_addr = ^addr[1:0];

   assign hit     = en && (addr[31:16] == BASE[31:16]);
   assign offset  = {addr[15:2], 2'b00};
   assign rd_hit  = hit && (wen == 4'b0000);
   assign wr_hit  = hit && (wen != 4'b0000);
   assign rd_miss = en && !hit && (wen == 4'b0000);

   assign wr_led     = wr_hit && (offset == OFF_LED);
   assign wr_timer   = wr_hit && (offset == OFF_TIMER);
   assign wr_compare = wr_hit && (offset == OFF_COMPARE);
   assign wr_status  = wr_hit && (offset == OFF_STATUS);
   assign wr_txdata  = wr_hit && (offset == OFF_TXDATA);
   assign wr_scratch = wr_hit && (offset == OFF_SCRATCH);

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_C);
   assign pop        = !fifo_empty && tx_ready;
   assign push_req   = wr_txdata && wen[0];
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push       = push_req && (!fifo_full || pop);

   assign irq_clr = wr_compare || (wr_status && wen[0] && wdata[0]);
   assign ovf_clr = wr_status && wen[0] && wdata[1];

   assign status_word = {16'h0000, 8'(count_q), 4'h0, fifo_full, fifo_empty, ovf_q, irq_q};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      rd_mux = 32'h0000_0000;
      case (offset)
         OFF_LED:     rd_mux = {16'h0000, led_q};
         OFF_SWITCH:  rd_mux = {16'h0000, switch_in};
         OFF_TIMER:   rd_mux = timer_q;
         OFF_COMPARE: rd_mux = compare_q;
         OFF_STATUS:  rd_mux = status_word;
         OFF_SCRATCH: rd_mux = scratch_q;
         default:     rd_mux = 32'h0000_0000;
      endcase
   end

   always_comb begin
      rdata_d   = rdata_q;
      led_d     = led_q;
      compare_d = compare_q;
      scratch_d = scratch_q;
      irq_d     = irq_q;
      ovf_d     = ovf_q;
      fifo_d    = fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (rd_hit) begin
         rdata_d = rd_mux;
      end else if (rd_miss) begin
         rdata_d = 32'h0000_0000;
      end

      if (wr_led) begin
         led_d[7:0]  = wen[0] ? wdata[7:0]  : led_q[7:0];
         led_d[15:8] = wen[1] ? wdata[15:8] : led_q[15:8];
      end

      timer_d = wr_timer ? merge_bytes(timer_q, wdata, wen) : timer_q + 32'd1;

      if (wr_compare) compare_d = merge_bytes(compare_q, wdata, wen);
      if (wr_scratch) scratch_d = merge_bytes(scratch_q, wdata, wen);

      // Clearing wins over a match in the same cycle.
      if (irq_clr) begin
         irq_d = 1'b0;
      end else if (timer_q == compare_q) begin
         irq_d = 1'b1;
      end

      if (ovf_clr) begin
         ovf_d = 1'b0;
      end else if (push_req && !push) begin
         ovf_d = 1'b1;
      end

      if (push) begin
         fifo_d[wr_ptr_q] = wdata[7:0];
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q   <= '0;
         led_q     <= '0;
         timer_q   <= '0;
         compare_q <= 32'hFFFF_FFFF;
         scratch_q <= '0;
         irq_q     <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         // NOTE: the FIFO storage is reset on purpose: tx_data must read 0 after
         // reset, and the array is only a handful of bytes.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         timer_q   <= timer_d;
         compare_q <= compare_d;
         scratch_q <= scratch_d;
         irq_q     <= irq_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         fifo_q    <= fifo_d;
      end
   end

   assign rdata     = rdata_q;
   assign led_out   = led_q;
   assign timer_irq = irq_q;
   assign tx_valid  = !fifo_empty;
   assign tx_data   = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_sram_periph_responder.sv
// Directed bench for sram_periph_responder: register map, timer/compare,
// TX FIFO full/overflow/drain, read miss and mid-operation reset.
module tb_sram_periph_responder;

   localparam logic [31:0] B        = 32'h1FAF_0000;
   localparam logic [31:0] A_LED    = B + 32'h00;
   localparam logic [31:0] A_SWITCH = B + 32'h04;
   localparam logic [31:0] A_TIMER  = B + 32'h08;
   localparam logic [31:0] A_CMP    = B + 32'h0C;
   localparam logic [31:0] A_STATUS = B + 32'h10;
   localparam logic [31:0] A_TXDATA = B + 32'h14;
   localparam logic [31:0] A_SCR    = B + 32'h18;
   localparam logic [31:0] A_UNMAP  = B + 32'h1C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [3:0]  wen = 4'b0000;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [15:0] switch_in = '0;
   logic [15:0] led_out;
   logic        timer_irq;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   sram_periph_responder #(.BASE(B), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .wen       (wen),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .switch_in (switch_in),
      .led_out   (led_out),
      .timer_irq (timer_irq),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      en = 1'b1; wen = be; addr = a; wdata = d;
      tick();
      en = 1'b0; wen = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a);
      en = 1'b1; wen = 4'b0000; addr = a;
      tick();
      en = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_a [4];
      logic [7:0] exp_b [4];
      exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_b = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

      tick(); tick();
      rst = 1'b0;
      check("rst_led", {16'h0, led_out}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_txvalid", {31'h0, tx_valid}, 32'h0);
      check("rst_txdata", {24'h0, tx_data}, 32'h0);
      check("rst_irq", {31'h0, timer_irq}, 32'h0);

      rd(A_STATUS);  check("rst_status", rdata, 32'h0000_0004);
      rd(A_CMP);     check("rst_compare", rdata, 32'hFFFF_FFFF);

      wr(A_LED, 32'h0000_A5A5, 4'b0001);  check("led_lane0", {16'h0, led_out}, 32'h0000_00A5);
      wr(A_LED, 32'h0000_3C00, 4'b0010);  check("led_lane1", {16'h0, led_out}, 32'h0000_3CA5);
      check("rdata_hold_on_write", rdata, 32'hFFFF_FFFF);
      switch_in = 16'h1234;
      rd(A_SWITCH);  check("switch_read", rdata, 32'h0000_1234);
      rd(A_LED);     check("led_read", rdata, 32'h0000_3CA5);

      wr(A_SCR, 32'hDEAD_BEEF, 4'b1111);
      wr(A_SCR, 32'h0000_0012, 4'b0001);
      rd(A_SCR);     check("scratch_merge", rdata, 32'hDEAD_BE12);
      rd(A_TXDATA);  check("txdata_reads0", rdata, 32'h0);
      rd(A_SCR);
      rd(A_UNMAP);   check("unmapped_reads0", rdata, 32'h0);

      // Timer wraps FFFFFFFE -> FFFFFFFF -> 0 -> 1 -> 2; irq sets on the edge sampling 2.
      wr(A_CMP, 32'h0000_0002, 4'b1111);
      wr(A_TIMER, 32'hFFFF_FFFE, 4'b1111);
      rd(A_TIMER);   check("timer_written", rdata, 32'hFFFF_FFFE);
      tick(); tick(); tick();
      check("irq_before_match", {31'h0, timer_irq}, 32'h0);
      rd(A_STATUS);  check("status_at_match_edge", rdata, 32'h0000_0004);
      check("irq_at_match", {31'h0, timer_irq}, 32'h1);
      rd(A_TIMER);   check("timer_wrapped", rdata, 32'h0000_0003);
      rd(A_STATUS);  check("status_irq", rdata, 32'h0000_0005);
      wr(A_TIMER, 32'h0000_0002, 4'b1111);
      check("irq_held", {31'h0, timer_irq}, 32'h1);
      wr(A_STATUS, 32'h0000_0001, 4'b0001);
      check("irq_clr_beats_set", {31'h0, timer_irq}, 32'h0);
      tick();
      check("irq_stays_clear", {31'h0, timer_irq}, 32'h0);

      // Fill past capacity with the consumer stalled.
      tx_ready = 1'b0;
      wr(A_TXDATA, 32'h0000_0011, 4'b0001);
      wr(A_TXDATA, 32'h0000_0022, 4'b0001);
      wr(A_TXDATA, 32'h0000_0033, 4'b0001);
      wr(A_TXDATA, 32'h0000_0044, 4'b0001);
      wr(A_TXDATA, 32'h0000_0055, 4'b0001);
      rd(A_STATUS);  check("status_full_ovf", rdata, 32'h0000_040A);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain1_valid", {31'h0, tx_valid}, 32'h1);
         check("drain1_data", {24'h0, tx_data}, {24'h0, exp_a[i]});
         tick();
      end
      check("drain1_empty", {31'h0, tx_valid}, 32'h0);

      wr(A_TXDATA, 32'h0000_005A, 4'b0001);
      check("empty_pushpop_valid", {31'h0, tx_valid}, 32'h1);
      check("empty_pushpop_data", {24'h0, tx_data}, 32'h0000_005A);
      tick();
      check("empty_after_pop", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      wr(A_STATUS, 32'h0000_0002, 4'b0001);
      rd(A_STATUS);  check("ovf_cleared", rdata, 32'h0000_0004);

      wr(A_TXDATA, 32'h0000_00A1, 4'b0001);
      wr(A_TXDATA, 32'h0000_00A2, 4'b0001);
      wr(A_TXDATA, 32'h0000_00A3, 4'b0001);
      wr(A_TXDATA, 32'h0000_00A4, 4'b0001);
      tx_ready = 1'b1;
      wr(A_TXDATA, 32'h0000_0066, 4'b0001);
      tx_ready = 1'b0;
      rd(A_STATUS);  check("full_pushpop_status", rdata, 32'h0000_0408);
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain2_data", {24'h0, tx_data}, {24'h0, exp_b[i]});
         tick();
      end
      check("drain2_empty", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;

      rd(32'h0000_1000);  check("read_miss", rdata, 32'h0);
      rd(A_SCR);          check("scratch_before_rst", rdata, 32'hDEAD_BE12);

      wr(A_TXDATA, 32'h0000_0077, 4'b0001);
      wr(A_TXDATA, 32'h0000_0088, 4'b0001);
      tx_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_txvalid", {31'h0, tx_valid}, 32'h0);
      check("midrst_txdata", {24'h0, tx_data}, 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      check("midrst_led", {16'h0, led_out}, 32'h0);
      check("midrst_irq", {31'h0, timer_irq}, 32'h0);
      rd(A_TIMER);   check("midrst_timer", rdata, 32'h0);
      rd(A_STATUS);  check("midrst_status", rdata, 32'h0000_0004);
      rd(A_SCR);     check("midrst_scratch", rdata, 32'h0);
      rd(A_CMP);     check("midrst_compare", rdata, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_periph_responder.md
Name: sram_periph_responder

Overview:
- Responder (slave) end of the SRAM-style data port that the CPU top drives: en, wen, addr, wdata out; rdata back.
- Decodes a small peripheral window and provides LED/switch registers, a free-running timer with compare interrupt, a scratch register and a byte TX FIFO with valid/ready drain.
- Sits beside data SRAM behind the address decoder; read data returns one cycle after the request, matching the SRAM timing the datapath expects.

Parameters:
- BASE, 32'h1FAF_0000, physical base address of the 64 KB window (addr[31:16] compared against BASE[31:16]).
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  request valid this cycle
- wen  in  4  byte write enables; 0 = read, nonzero = write
- addr  in  32  physical byte address; addr[1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, registered
- switch_in  in  16  board switches (already synchronised)
- led_out  out  16  LED register
- timer_irq  out  1  level interrupt = irq_pend
- tx_valid  out  1  FIFO head valid (= not empty)
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts head

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: rdata=0, led_out=0, timer=0, compare=32'hFFFF_FFFF, scratch=0, irq_pend=0, overflow=0, FIFO empty (tx_valid=0, tx_data=0, count=0).
- Hit: en=1 and addr[31:16]==BASE[31:16]. Offset = addr[15:0], word-aligned.
- Register map:
  - 0x00 LED RW [15:0]
  - 0x04 SWITCH RO
  - 0x08 TIMER RW
  - 0x0C COMPARE RW
  - 0x10 STATUS: bit0 irq_pend W1C; bit1 overflow W1C; bit2 empty RO; bit3 full RO; [15:8] count RO
  - 0x14 TXDATA WO, reads 0
  - 0x18 SCRATCH RW
  - All other offsets read 0; writes to them are ignored.
- Reads (hit, wen=0): the selected value as sampled at edge N appears on rdata after edge N and holds until the next read hit.
  - A non-hit cycle or a write leaves rdata unchanged.
  - A read miss (en=1, outside window) loads rdata=0.
- Writes: committed at the request edge. Byte lanes are merged per wen bit; unselected bytes keep their old value.
- Timer:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - On a TIMER write, the next value is the byte-merged write of the current value; no increment that cycle.
- Compare:
  - irq_pend sets at the edge where the current timer == compare.
  - A COMPARE write, or a STATUS write with wdata[0]=1 and wen[0]=1, clears irq_pend. The clear has priority over a same-cycle set.
  - Overflow is cleared by a STATUS write with wen[0]=1 and wdata[1]=1.
- TX FIFO (circular, wr/rd pointers plus count):
  - Push: a TXDATA write with wen[0]=1 pushes wdata[7:0].
  - Pop: tx_valid & tx_ready.
  - Push when full with no pop: the push is dropped and overflow sets (sticky).
  - Full with simultaneous push and pop: both happen and count is unchanged.
  - Empty with simultaneous push and pop: no pop occurs; the push is accepted.
  - tx_data = head entry; it is 0 only after reset, and otherwise stale when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all state returns to reset values at that edge. FIFO contents are discarded and a pending rdata is cleared.
- Requests are single-cycle with no back-pressure; the responder never stalls.

Test Plan:
- Reset, then read 0x10 -> rdata=32'h0000_0004 one cycle later; read 0x0C -> 32'hFFFF_FFFF; led_out=0.
- Write LED=32'h0000_A5A5 with wen=4'b0001 -> led_out=16'h00A5; then wen=4'b0010, wdata=32'h0000_3C00 -> led_out=16'h3CA5; read 0x04 with switch_in=16'h1234 -> rdata=32'h0000_1234.
- Write TIMER=32'hFFFF_FFFE, COMPARE=32'h0000_0002 -> timer wraps through 0, irq_pend/timer_irq rise at the edge where timer==2. Writing STATUS=1 in the same cycle as a repeat match -> irq_pend=0.
- With tx_ready=0, push 5 bytes 0x11..0x55 -> STATUS count=4, full=1, overflow=1. Raise tx_ready -> drain order 0x11,0x22,0x33,0x44, then tx_valid=0.
- With the FIFO full and tx_ready=1, push 0x66 in the same cycle -> count stays 4, overflow stays 0, and 0x66 appears last.
- Read miss at 32'h0000_1000 -> rdata=0. Assert rst during FIFO drain -> next cycle tx_valid=0 and all registers are at reset values.
